// File: rtl/data_utlb.sv
// Micro data-TLB for MEM-stage lookups: 1-cycle hits, refill from the main TLB on miss.
// Optional UTLB_PERF_CNT_EN adds hit/miss performance counters.
module data_utlb #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_vaddr,
  input  logic [9:0]  lookup_asid,
  input  logic        lookup_trans_en,
  input  logic [19:0] lookup_direct_ppn,
  output logic        lookup_ready,
  output logic        resp_valid,
  output logic        resp_found,
  output logic        resp_v,
  output logic        resp_d,
  output logic [1:0]  resp_plv,
  output logic [19:0] resp_tag,
  output logic [4:0]  resp_index,
  output logic        refill_req,
  output logic [31:0] refill_vaddr,
  output logic [9:0]  refill_asid,
  input  logic        refill_ack,
  input  logic        refill_found,
  input  logic [19:0] refill_ppn,
  input  logic [5:0]  refill_ps,
  input  logic        refill_g,
  input  logic        refill_v,
  input  logic        refill_d,
  input  logic [1:0]  refill_plv,
  input  logic [4:0]  refill_index,
  input  logic        inv_all
`ifdef UTLB_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_g;
  logic [ENTRIES-1:0] ent_ps21;
  logic [ENTRIES-1:0] ent_v;
  logic [ENTRIES-1:0] ent_d;
  logic [9:0]         ent_asid  [ENTRIES];
  logic [19:0]        ent_vpn   [ENTRIES];
  logic [19:0]        ent_ppn   [ENTRIES];
  logic [1:0]         ent_plv   [ENTRIES];
  logic [4:0]         ent_index [ENTRIES];

  logic [PW-1:0]      repl_ptr;
  logic               inv_seen;

  logic [ENTRIES-1:0] match;
  logic               hit;
  logic [PW-1:0]      hit_sel;
  logic [19:0]        hit_tag;
  logic [19:0]        refill_tag;
  logic               accept;
  logic               install;
  logic               unused_vaddr_lo;

  assign unused_vaddr_lo = ^lookup_vaddr[11:0];

  assign accept  = lookup_valid && (state_q == IDLE);
  assign install = (state_q == REFILL) && refill_ack && refill_found &&
                   !inv_all && !inv_seen && !rst;

  // A 2 MB entry ignores the low 9 VPN bits; lowest matching index wins.
  always_comb begin
    match   = '0;
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = ent_valid[i] &&
                 (ent_g[i] || (ent_asid[i] == lookup_asid)) &&
                 (ent_vpn[i][19:9] == lookup_vaddr[31:21]) &&
                 (ent_ps21[i] || (ent_vpn[i][8:0] == lookup_vaddr[20:12]));
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_sel = PW'(i);
      end
    end
  end

  assign hit_tag    = ent_ps21[hit_sel] ? {ent_ppn[hit_sel][19:9], lookup_vaddr[20:12]}
                                        : ent_ppn[hit_sel];
  assign refill_tag = (refill_ps == 6'd21) ? {refill_ppn[19:9], refill_vaddr[20:12]}
                                           : refill_ppn;

  assign lookup_ready = (state_q == IDLE) && !rst;
  assign refill_req   = (state_q == REFILL) && !refill_ack && !rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && lookup_trans_en && !hit) state_d = REFILL;
      REFILL:  if (refill_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_found   <= 1'b0;
      resp_v       <= 1'b0;
      resp_d       <= 1'b0;
      resp_plv     <= 2'd0;
      resp_tag     <= 20'd0;
      resp_index   <= 5'd0;
      refill_vaddr <= 32'd0;
      refill_asid  <= 10'd0;
      inv_seen     <= 1'b0;
      repl_ptr     <= '0;
      ent_valid    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        if (!lookup_trans_en) begin
          resp_valid <= 1'b1;
          resp_found <= 1'b1;
          resp_v     <= 1'b1;
          resp_d     <= 1'b1;
          resp_plv   <= 2'd0;
          resp_tag   <= lookup_direct_ppn;
          resp_index <= 5'd0;
        end else if (hit) begin
          resp_valid <= 1'b1;
          resp_found <= 1'b1;
          resp_v     <= ent_v[hit_sel];
          resp_d     <= ent_d[hit_sel];
          resp_plv   <= ent_plv[hit_sel];
          resp_tag   <= hit_tag;
          resp_index <= ent_index[hit_sel];
        end else begin
          refill_vaddr <= lookup_vaddr;
          refill_asid  <= lookup_asid;
          inv_seen     <= 1'b0;
        end
      end
      if (state_q == REFILL) begin
        if (inv_all) inv_seen <= 1'b1;
        if (refill_ack) begin
          resp_valid <= 1'b1;
          resp_found <= refill_found;
          resp_v     <= refill_v;
          resp_d     <= refill_d;
          resp_plv   <= refill_plv;
          resp_tag   <= refill_tag;
          resp_index <= refill_index;
        end
      end
      if (install) begin
        ent_valid[repl_ptr] <= 1'b1;
        repl_ptr            <= repl_ptr + 1'b1;
      end
      // Invalidate wins over a same-cycle install.
      if (inv_all) ent_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      ent_g[repl_ptr]     <= refill_g;
      ent_ps21[repl_ptr]  <= (refill_ps == 6'd21);
      ent_v[repl_ptr]     <= refill_v;
      ent_d[repl_ptr]     <= refill_d;
      ent_asid[repl_ptr]  <= refill_asid;
      ent_vpn[repl_ptr]   <= refill_vaddr[31:12];
      ent_ppn[repl_ptr]   <= refill_ppn;
      ent_plv[repl_ptr]   <= refill_plv;
      ent_index[repl_ptr] <= refill_index;
    end
  end

`ifdef UTLB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_cnt  <= 32'd0;
      perf_miss_cnt <= 32'd0;
    end else if (accept && lookup_trans_en) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_utlb.sv
// Self-checking bench for data_utlb: directed scenarios plus randomized lookups
// against a page-arithmetic reference model.
module tb_data_utlb;
  localparam int ENTRIES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_vaddr = '0;
  logic [9:0]  lookup_asid = '0;
  logic        lookup_trans_en = 1'b0;
  logic [19:0] lookup_direct_ppn = '0;
  logic        lookup_ready;
  logic        resp_valid, resp_found, resp_v, resp_d;
  logic [1:0]  resp_plv;
  logic [19:0] resp_tag;
  logic [4:0]  resp_index;
  logic        refill_req;
  logic [31:0] refill_vaddr;
  logic [9:0]  refill_asid;
  logic        refill_ack = 1'b0, refill_found = 1'b0;
  logic [19:0] refill_ppn = '0;
  logic [5:0]  refill_ps = 6'd12;
  logic        refill_g = 1'b0, refill_v = 1'b0, refill_d = 1'b0;
  logic [1:0]  refill_plv = '0;
  logic [4:0]  refill_index = '0;
  logic        inv_all = 1'b0;
`ifdef UTLB_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  data_utlb #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_vaddr(lookup_vaddr), .lookup_asid(lookup_asid),
    .lookup_trans_en(lookup_trans_en), .lookup_direct_ppn(lookup_direct_ppn),
    .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_found(resp_found), .resp_v(resp_v), .resp_d(resp_d),
    .resp_plv(resp_plv), .resp_tag(resp_tag), .resp_index(resp_index),
    .refill_req(refill_req), .refill_vaddr(refill_vaddr), .refill_asid(refill_asid),
    .refill_ack(refill_ack), .refill_found(refill_found), .refill_ppn(refill_ppn),
    .refill_ps(refill_ps), .refill_g(refill_g), .refill_v(refill_v), .refill_d(refill_d),
    .refill_plv(refill_plv), .refill_index(refill_index), .inv_all(inv_all)
`ifdef UTLB_PERF_CNT_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  typedef struct {
    bit valid, g, v, d;
    bit [9:0]  asid;
    bit [19:0] vpn, ppn;
    bit [1:0]  plv;
    bit [4:0]  idx;
    int        sh;
  } ment_t;

  typedef struct {
    bit found, g, v, d;
    bit [19:0] ppn;
    int        ps;
    bit [1:0]  plv;
    bit [4:0]  idx;
  } rf_t;

  ment_t m[ENTRIES];
  int    m_ptr = 0;
  int    n_hit = 0, n_miss = 0;

  bit        e_rv, e_found, e_v, e_d, e_ready, e_req;
  bit [1:0]  e_plv;
  bit [19:0] e_tag;
  bit [4:0]  e_idx;
  bit [31:0] e_rvaddr;
  bit [9:0]  e_rasid;

  int passed = 0, total = 0;
  bit chk_en = 0;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("lookup_ready", lookup_ready, e_ready);
      check("resp_valid", resp_valid, e_rv);
      check("resp_found", resp_found, e_found);
      check("resp_v", resp_v, e_v);
      check("resp_d", resp_d, e_d);
      check("resp_plv", resp_plv, e_plv);
      check("resp_tag", resp_tag, e_tag);
      check("resp_index", resp_index, e_idx);
      check("refill_req", refill_req, e_req);
      check("refill_vaddr", refill_vaddr, e_rvaddr);
      check("refill_asid", refill_asid, e_rasid);
    end
  end

  // Physical tag from page arithmetic: frame base bits above the page offset, vaddr below.
  function automatic bit [19:0] page_tag(bit [19:0] ppn, int sh, bit [31:0] va);
    bit [31:0] mask;
    bit [31:0] pa;
    mask = (32'h1 << sh) - 32'h1;
    pa   = ({ppn, 12'h000} & ~mask) | (va & mask);
    return pa[31:12];
  endfunction

  function automatic int mfind(bit [31:0] va, bit [9:0] as);
    for (int i = 0; i < ENTRIES; i++)
      if (m[i].valid && (m[i].g || m[i].asid == as) &&
          ((va >> m[i].sh) == ({m[i].vpn, 12'h000} >> m[i].sh)))
        return i;
    return -1;
  endfunction

  function automatic void mclear();
    for (int i = 0; i < ENTRIES; i++) m[i].valid = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lookup_valid = 1'b0;
    refill_ack = 1'b0;
    inv_all = 1'b0;
    e_req = 0;
    e_ready = 0;
    tick();
    {e_rv, e_found, e_v, e_d, e_plv, e_tag, e_idx, e_rvaddr, e_rasid} = '0;
    mclear();
    m_ptr = 0;
    n_hit = 0;
    n_miss = 0;
    tick();
    rst = 1'b0;
    e_ready = 1;
  endtask

  // inv_mode: 0 none, 1 with the lookup, 2 first REFILL cycle, 3 on the ack cycle
  task automatic lookup(input bit [31:0] va, input bit [9:0] as, input bit te,
                        input bit [19:0] dppn, input rf_t rf, input int delay,
                        input int inv_mode);
    int sel;
    bit inv_seen;
    lookup_valid = 1'b1;
    lookup_vaddr = va;
    lookup_asid = as;
    lookup_trans_en = te;
    lookup_direct_ppn = dppn;
    inv_all = (inv_mode == 1);
    sel = te ? mfind(va, as) : -1;
    tick();
    lookup_valid = 1'b0;
    inv_all = 1'b0;
    if (!te) begin
      {e_rv, e_found, e_v, e_d} = 4'b1111;
      e_plv = 0;
      e_tag = dppn;
      e_idx = 0;
    end else if (sel >= 0) begin
      n_hit++;
      e_rv = 1;
      e_found = 1;
      e_v = m[sel].v;
      e_d = m[sel].d;
      e_plv = m[sel].plv;
      e_tag = page_tag(m[sel].ppn, m[sel].sh, va);
      e_idx = m[sel].idx;
    end else begin
      n_miss++;
      if (inv_mode == 1) mclear();
      e_rv = 0;
      e_ready = 0;
      e_req = 1;
      e_rvaddr = va;
      e_rasid = as;
      inv_seen = 0;
      for (int k = 0; k < delay; k++) begin
        if (inv_mode == 2 && k == 0) begin
          inv_all = 1'b1;
          inv_seen = 1;
        end
        lookup_valid = 1'($urandom_range(0, 1));
        lookup_vaddr = $urandom;
        lookup_trans_en = 1'($urandom_range(0, 1));
        tick();
        if (inv_all) mclear();
        inv_all = 1'b0;
      end
      lookup_valid = 1'b0;
      refill_ack = 1'b1;
      refill_found = rf.found;
      refill_ppn = rf.ppn;
      refill_ps = 6'(rf.ps);
      refill_g = rf.g;
      refill_v = rf.v;
      refill_d = rf.d;
      refill_plv = rf.plv;
      refill_index = rf.idx;
      e_req = 0;
      if (inv_mode == 3 || (inv_mode == 2 && delay == 0)) begin
        inv_all = 1'b1;
        inv_seen = 1;
      end
      tick();
      refill_ack = 1'b0;
      refill_ppn = $urandom;
      if (inv_all) mclear();
      inv_all = 1'b0;
      e_rv = 1;
      e_found = rf.found;
      e_v = rf.v;
      e_d = rf.d;
      e_plv = rf.plv;
      e_idx = rf.idx;
      e_tag = page_tag(rf.ppn, rf.ps, va);
      if (rf.found && !inv_seen) begin
        m[m_ptr].valid = 1;
        m[m_ptr].g = rf.g;
        m[m_ptr].v = rf.v;
        m[m_ptr].d = rf.d;
        m[m_ptr].asid = as;
        m[m_ptr].vpn = va[31:12];
        m[m_ptr].ppn = rf.ppn;
        m[m_ptr].plv = rf.plv;
        m[m_ptr].idx = rf.idx;
        m[m_ptr].sh = rf.ps;
        m_ptr = (m_ptr + 1) % ENTRIES;
      end
      tick();
      e_rv = 0;
      e_ready = 1;
      return;
    end
    if (inv_mode == 1) mclear();
    e_ready = 1;
    e_req = 0;
  endtask

  task automatic idle_cycle(input bit inv);
    inv_all = inv;
    tick();
    if (inv) mclear();
    inv_all = 1'b0;
    e_rv = 0;
  endtask

  function automatic rf_t mk_rf(bit found, bit [19:0] ppn, int ps, bit g, bit v, bit d,
                                bit [1:0] plv, bit [4:0] idx);
    rf_t r;
    r.found = found; r.ppn = ppn; r.ps = ps; r.g = g;
    r.v = v; r.d = d; r.plv = plv; r.idx = idx;
    return r;
  endfunction

  initial begin
    rf_t none, r;
    none = mk_rf(0, 0, 12, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1;
    do_reset();

    // direct / bypass translation
    lookup(32'h1234_5678, 10'd0, 1'b0, 20'h1C000, none, 0, 0);
    check("t1_valid", resp_valid, 1);
    check("t1_found", resp_found, 1);
    check("t1_tag", resp_tag, 20'h1C000);
    check("t1_no_req", refill_req, 0);

    // cold miss, refill after 3 cycles, then hit
    r = mk_rf(1, 20'h12345, 12, 0, 1, 0, 2'd3, 5'd7);
    lookup(32'h0040_1234, 10'd5, 1'b1, 0, r, 3, 0);
    check("t2_refill_vaddr", refill_vaddr, 32'h0040_1234);
    check("t2_tag", resp_tag, 20'h12345);
    check("t2_index", resp_index, 7);
    lookup(32'h0040_1234, 10'd5, 1'b1, 0, none, 0, 0);
    check("t2_hit_valid", resp_valid, 1);
    check("t2_hit_tag", resp_tag, 20'h12345);
    check("t2_hit_plv", resp_plv, 3);

    // 2 MB page
    r = mk_rf(1, 20'h20000, 21, 0, 1, 1, 2'd0, 5'd9);
    lookup(32'h0080_0000, 10'd5, 1'b1, 0, r, 1, 0);
    lookup(32'h009F_F123, 10'd5, 1'b1, 0, none, 0, 0);
    check("t3_hit_tag", resp_tag, 20'h201FF);
    check("t3_hit_index", resp_index, 9);
    lookup(32'h00A0_0000, 10'd5, 1'b1, 0, none, 2, 0);
    check("t3_miss_found", resp_found, 0);

    // ASID / global
    do_reset();
    r = mk_rf(1, 20'h11111, 12, 0, 1, 0, 2'd1, 5'd3);
    lookup(32'h0100_0000, 10'd5, 1'b1, 0, r, 0, 0);
    r = mk_rf(1, 20'h0ABCD, 12, 1, 1, 0, 2'd2, 5'd4);
    lookup(32'h0100_0000, 10'd6, 1'b1, 0, r, 1, 0);
    check("t4_asid_miss_idx", resp_index, 4);
    lookup(32'h0100_0000, 10'd7, 1'b1, 0, none, 0, 0);
    check("t4_global_tag", resp_tag, 20'h0ABCD);
    lookup(32'h0100_0000, 10'd5, 1'b1, 0, none, 0, 0);
    check("t4_own_asid_tag", resp_tag, 20'h11111);

    // eviction round-robin
    do_reset();
    for (int i = 0; i <= ENTRIES; i++) begin
      r = mk_rf(1, 20'h00100 + 20'(i), 12, 0, 1, 0, 0, 5'(i));
      lookup(32'h1000_0000 + (i << 12), 10'd5, 1'b1, 0, r, i % 3, 0);
    end
    lookup(32'h1000_0000, 10'd5, 1'b1, 0, none, 1, 0);
    check("t5_evicted_found", resp_found, 0);
    for (int i = 1; i <= ENTRIES; i++) begin
      lookup(32'h1000_0000 + (i << 12), 10'd5, 1'b1, 0, none, 0, 0);
      check("t5_kept_tag", resp_tag, 20'h00100 + 20'(i));
    end

    // inv_all during refill
    do_reset();
    r = mk_rf(1, 20'h0F0F0, 12, 0, 1, 1, 0, 5'd2);
    lookup(32'h0200_0000, 10'd5, 1'b1, 0, r, 2, 2);
    check("t6_resp_found", resp_found, 1);
    lookup(32'h0200_0000, 10'd5, 1'b1, 0, none, 0, 0);
    check("t6_not_installed", resp_found, 0);

    // reset mid-refill drops the request at once
    do_reset();
    lookup_valid = 1'b1; lookup_vaddr = 32'h0300_0000; lookup_asid = 10'd5;
    lookup_trans_en = 1'b1;
    tick();
    lookup_valid = 1'b0;
    e_ready = 0; e_req = 1; e_rvaddr = 32'h0300_0000; e_rasid = 10'd5;
    tick();
    rst = 1'b1;
    #1;
    check("t7_req_drop", refill_req, 0);
    do_reset();
    check("t7_vaddr_cleared", refill_vaddr, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit [31:0] va;
      int sel;
      va = {9'h0, 2'($urandom_range(0, 3)), 6'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
      r = mk_rf($urandom_range(0, 9) < 8, 20'($urandom),
                ($urandom_range(0, 2) == 0) ? 21 : 12, $urandom_range(0, 9) < 3,
                1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom));
      sel = $urandom_range(0, 19);
      lookup(va, 10'($urandom_range(5, 6)), $urandom_range(0, 9) != 0, 20'($urandom), r,
             $urandom_range(0, 4), (sel < 3) ? sel + 1 : 0);
      if ($urandom_range(0, 5) == 0) idle_cycle($urandom_range(0, 7) == 0);
    end
    idle_cycle(0);

`ifdef UTLB_PERF_CNT_EN
    check("perf_hit_cnt", perf_hit_cnt, n_hit);
    check("perf_miss_cnt", perf_miss_cnt, n_miss);
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
